// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline issue/write-back controller.
package pipe_ctrl_pkg;

   localparam int NREGS_DEF = 16;

   // Bit positions of the condition flags inside a 4-bit N,Z,C,V word
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic {
      WB_IDLE   = 1'b0,
      WB_SECOND = 1'b1
   } wb_state_t;

   // One issued instruction waiting for its results, oldest first
   typedef struct packed {
      logic       dst0En;
      logic [3:0] dst0;
      logic       dst1En;
      logic [3:0] dst1;
      logic       setFlags;
   } queue_entry_t;

   localparam int QENTRY_W = $bits(queue_entry_t);

endpackage

// File: rtl/pipe_ctrl_queue.sv
// Show-ahead synchronous FIFO: the head entry is visible on o_head whenever
// the queue is not empty. Push into a full queue and pop from an empty queue
// are ignored.
module pipe_ctrl_queue #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk1,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [CW-1:0]    r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign w_doPush = i_push & ~o_full;
   assign w_doPop  = i_pop & ~o_empty;
   assign o_full   = (r_count == CW'(DEPTH));
   assign o_empty  = (r_count == '0);
   assign o_head   = r_mem[r_rdPtr];

   // Storage array needs no reset; only the pointers decide what is valid
   always_ff @(posedge clk1) begin
      if (w_doPush) r_mem[r_wrPtr] <= i_data;
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
         if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Issue and write-back controller: register scoreboard with RAW/WAW stall,
// in-order queue of issued destinations, and sequencing of the single
// register-file write port plus CPSR write.
// Optional build macro PIPE_HAZARD_STATS_EN adds stall_count and raw_count.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int NREGS = NREGS_DEF
) (
   input  logic             clk1,
   input  logic             rst_n,
   input  logic             dec_valid,
   output logic             dec_ready,
   input  logic [NREGS-1:0] dec_src_mask,
   input  logic             dec_dst0_en,
   input  logic [3:0]       dec_dst0,
   input  logic             dec_dst1_en,
   input  logic [3:0]       dec_dst1,
   input  logic             dec_setflags,
   output logic             issue_valid,
   input  logic             exec_done,
   output logic             wb_ready,
   input  logic [31:0]      res0,
   input  logic [31:0]      res1,
   input  logic [3:0]       res_flags,
   output logic             rf_we,
   output logic [3:0]       rf_waddr,
   output logic [31:0]      rf_wdata,
   output logic             cpsr_we,
   output logic [3:0]       cpsr_wdata,
   output logic [NREGS-1:0] busy_mask,
   output logic             stall
`ifdef PIPE_HAZARD_STATS_EN
   ,
   output logic [31:0]      stall_count,
   output logic [31:0]      raw_count
`endif
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [NREGS-1:0] w_dst0Mask;
   logic [NREGS-1:0] w_dst1Mask;
   logic [NREGS-1:0] w_incMask;
   logic [NREGS-1:0] w_retireMask;
   logic             w_hazard;
   logic             w_full;
   logic             w_empty;
   logic             w_issue;
   queue_entry_t     w_pushEntry;
   queue_entry_t     w_head;
   logic [QENTRY_W-1:0] w_headBits;
   logic [CW-1:0]    r_count [NREGS];

   wb_state_t        r_wbState;
   wb_state_t        w_wbNext;
   logic             w_pop;
   logic             w_retireEn;
   logic [3:0]       w_retireReg;
   logic             w_latchRes1;
   logic             r_rfWe,   w_rfWeNext;
   logic [3:0]       r_rfWaddr, w_rfWaddrNext;
   logic [31:0]      r_rfWdata, w_rfWdataNext;
   logic             r_cpsrWe, w_cpsrWeNext;
   logic [3:0]       r_cpsrWdata, w_cpsrWdataNext;
   logic [31:0]      r_res1;

   // Decoder side: stall while any touched register has a pending write,
   // or while the queue is full. Outputs read 0 while reset is held.
   assign w_dst0Mask = dec_dst0_en ? (NREGS'(1) << dec_dst0) : '0;
   assign w_dst1Mask = dec_dst1_en ? (NREGS'(1) << dec_dst1) : '0;
   assign w_hazard   = |((dec_src_mask | w_dst0Mask | w_dst1Mask) & busy_mask);
   assign dec_ready  = rst_n & ~w_full & ~w_hazard;
   assign w_issue    = dec_valid & dec_ready;
   assign issue_valid = w_issue;
   assign stall      = rst_n & dec_valid & ~dec_ready;
   assign wb_ready   = rst_n & (r_wbState == WB_IDLE);

   assign w_pushEntry = '{dst0En: dec_dst0_en, dst0: dec_dst0,
                          dst1En: dec_dst1_en, dst1: dec_dst1,
                          setFlags: dec_setflags};
   assign w_head = queue_entry_t'(w_headBits);

   pipe_ctrl_queue #(
      .WIDTH (QENTRY_W),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk1    (clk1),
      .rst_n   (rst_n),
      .i_push  (w_issue),
      .i_data  (w_pushEntry),
      .i_pop   (w_pop),
      .o_head  (w_headBits),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Write-back sequencing: decide next write-port contents, pop and retire
   always_comb begin
      w_wbNext        = r_wbState;
      w_pop           = 1'b0;
      w_retireEn      = 1'b0;
      w_retireReg     = '0;
      w_latchRes1     = 1'b0;
      w_rfWeNext      = 1'b0;
      w_rfWaddrNext   = r_rfWaddr;
      w_rfWdataNext   = r_rfWdata;
      w_cpsrWeNext    = 1'b0;
      w_cpsrWdataNext = r_cpsrWdata;
      case (r_wbState)
         WB_IDLE: begin
            if (exec_done && !w_empty) begin
               if (w_head.dst0En) begin
                  w_rfWeNext    = 1'b1;
                  w_rfWaddrNext = w_head.dst0;
                  w_rfWdataNext = res0;
                  w_retireEn    = 1'b1;
                  w_retireReg   = w_head.dst0;
               end
               if (w_head.setFlags) begin
                  w_cpsrWeNext    = 1'b1;
                  w_cpsrWdataNext = res_flags;
               end
               if (w_head.dst1En) begin
                  w_latchRes1 = 1'b1;
                  w_wbNext    = WB_SECOND;
               end else begin
                  w_pop = 1'b1;
               end
            end
         end
         WB_SECOND: begin
            w_rfWeNext    = 1'b1;
            w_rfWaddrNext = w_head.dst1;
            w_rfWdataNext = r_res1;
            w_retireEn    = 1'b1;
            w_retireReg   = w_head.dst1;
            w_pop         = 1'b1;
            w_wbNext      = WB_IDLE;
         end
         default: w_wbNext = WB_IDLE;
      endcase
   end

   // Registered write-port and CPSR outputs plus the WB state register
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         r_wbState   <= WB_IDLE;
         r_rfWe      <= 1'b0;
         r_rfWaddr   <= '0;
         r_rfWdata   <= '0;
         r_cpsrWe    <= 1'b0;
         r_cpsrWdata <= '0;
         r_res1      <= '0;
      end else begin
         r_wbState   <= w_wbNext;
         r_rfWe      <= w_rfWeNext;
         r_rfWaddr   <= w_rfWaddrNext;
         r_rfWdata   <= w_rfWdataNext;
         r_cpsrWe    <= w_cpsrWeNext;
         r_cpsrWdata <= w_cpsrWdataNext;
         if (w_latchRes1) r_res1 <= res1;
      end
   end

   assign rf_we      = r_rfWe;
   assign rf_waddr   = r_rfWaddr;
   assign rf_wdata   = r_rfWdata;
   assign cpsr_we    = r_cpsrWe;
   assign cpsr_wdata = r_cpsrWdata;

   // Scoreboard: pending-write count per register, decremented on the same
   // edge that raises the matching rf_we
   assign w_incMask    = w_issue ? (w_dst0Mask | w_dst1Mask) : '0;
   assign w_retireMask = w_retireEn ? (NREGS'(1) << w_retireReg) : '0;

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) r_count[r] <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            case ({w_incMask[r], w_retireMask[r]})
               2'b10:   r_count[r] <= r_count[r] + CW'(1);
               2'b01:   r_count[r] <= r_count[r] - CW'(1);
               default: r_count[r] <= r_count[r];
            endcase
         end
      end
   end

   // Busy view derived from the registered counters
   always_comb begin
      busy_mask = '0;
      for (int r = 0; r < NREGS; r++) busy_mask[r] = (r_count[r] != '0);
   end

`ifdef PIPE_HAZARD_STATS_EN
   logic        w_srcHazard;
   logic [31:0] r_stallCount;
   logic [31:0] r_rawCount;

   assign w_srcHazard = |(dec_src_mask & busy_mask);

   // Saturating stall statistics; raw_count excludes full-queue stalls
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         r_stallCount <= '0;
         r_rawCount   <= '0;
      end else begin
         if (stall && (r_stallCount != '1)) r_stallCount <= r_stallCount + 32'd1;
         if (stall && !w_full && w_srcHazard && (r_rawCount != '1))
            r_rawCount <= r_rawCount + 32'd1;
      end
   end

   assign stall_count = r_stallCount;
   assign raw_count   = r_rawCount;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a transaction-level model
// (queue of instructions, per-register pending counts, owed second write)
// is compared with the DUT on every falling clock edge, and directed
// scenarios add hand-computed literal checks.
module tb_pipe_hazard_ctrl;

   localparam int DEPTH = 4;
   localparam int NREGS = 16;

   logic             clk1 = 1'b0;
   logic             rst_n = 1'b1;
   logic             dec_valid = 1'b0;
   logic             dec_ready;
   logic [NREGS-1:0] dec_src_mask = '0;
   logic             dec_dst0_en = 1'b0;
   logic [3:0]       dec_dst0 = '0;
   logic             dec_dst1_en = 1'b0;
   logic [3:0]       dec_dst1 = '0;
   logic             dec_setflags = 1'b0;
   logic             issue_valid;
   logic             exec_done = 1'b0;
   logic             wb_ready;
   logic [31:0]      res0 = '0;
   logic [31:0]      res1 = '0;
   logic [3:0]       res_flags = '0;
   logic             rf_we;
   logic [3:0]       rf_waddr;
   logic [31:0]      rf_wdata;
   logic             cpsr_we;
   logic [3:0]       cpsr_wdata;
   logic [NREGS-1:0] busy_mask;
   logic             stall;
`ifdef PIPE_HAZARD_STATS_EN
   logic [31:0]      stall_count;
   logic [31:0]      raw_count;
`endif

   int total = 0;
   int bad = 0;
   bit checkEn = 1'b0;

   pipe_hazard_ctrl #(.DEPTH(DEPTH), .NREGS(NREGS)) dut (
      .clk1         (clk1),
      .rst_n        (rst_n),
      .dec_valid    (dec_valid),
      .dec_ready    (dec_ready),
      .dec_src_mask (dec_src_mask),
      .dec_dst0_en  (dec_dst0_en),
      .dec_dst0     (dec_dst0),
      .dec_dst1_en  (dec_dst1_en),
      .dec_dst1     (dec_dst1),
      .dec_setflags (dec_setflags),
      .issue_valid  (issue_valid),
      .exec_done    (exec_done),
      .wb_ready     (wb_ready),
      .res0         (res0),
      .res1         (res1),
      .res_flags    (res_flags),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .cpsr_we      (cpsr_we),
      .cpsr_wdata   (cpsr_wdata),
      .busy_mask    (busy_mask),
      .stall        (stall)
`ifdef PIPE_HAZARD_STATS_EN
      ,
      .stall_count  (stall_count),
      .raw_count    (raw_count)
`endif
   );

   // 10 ns clock
   always #5 clk1 = ~clk1;

   // ---------------- reference model ----------------
   typedef struct {
      bit       e0;
      bit [3:0] d0;
      bit       e1;
      bit [3:0] d1;
      bit       s;
   } ent_t;

   ent_t      mq[$];
   int        cnt[NREGS];
   bit        owe2;
   bit [3:0]  oweReg;
   bit [31:0] oweData;
   bit        eWe;
   bit [3:0]  eWaddr;
   bit [31:0] eWdata;
   bit        eCWe;
   bit [3:0]  eCData;
   bit        mIss;
   ent_t      mHead;
   ent_t      mNew;

   function automatic bit [NREGS-1:0] mBusy();
      bit [NREGS-1:0] b = '0;
      for (int i = 0; i < NREGS; i++) b[i] = (cnt[i] > 0);
      return b;
   endfunction

   function automatic bit mReady();
      bit [NREGS-1:0] touch;
      if (!rst_n) return 1'b0;
      touch = dec_src_mask;
      if (dec_dst0_en) touch[dec_dst0] = 1'b1;
      if (dec_dst1_en) touch[dec_dst1] = 1'b1;
      return (mq.size() < DEPTH) && ((touch & mBusy()) == '0);
   endfunction

   // Model advance: an owed second write takes priority, otherwise a result
   // retires the oldest instruction; issue appends a new one
   always @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         for (int i = 0; i < NREGS; i++) cnt[i] = 0;
         owe2 = 1'b0;
         eWe = 1'b0; eWaddr = '0; eWdata = '0; eCWe = 1'b0; eCData = '0;
      end else begin
         assert (!(dec_valid && dec_dst0_en && dec_dst1_en && dec_dst0 == dec_dst1))
            else $error("[TB] illegal stimulus: dst0 equals dst1");
         mIss = dec_valid && mReady();
         mNew = '{e0: dec_dst0_en, d0: dec_dst0, e1: dec_dst1_en, d1: dec_dst1, s: dec_setflags};
         eWe = 1'b0;
         eCWe = 1'b0;
         if (owe2) begin
            eWe = 1'b1; eWaddr = oweReg; eWdata = oweData;
            cnt[oweReg]--;
            void'(mq.pop_front());
            owe2 = 1'b0;
         end else if (exec_done && mq.size() > 0) begin
            mHead = mq[0];
            if (mHead.e0) begin
               eWe = 1'b1; eWaddr = mHead.d0; eWdata = res0;
               cnt[mHead.d0]--;
            end
            if (mHead.s) begin
               eCWe = 1'b1; eCData = res_flags;
            end
            if (mHead.e1) begin
               owe2 = 1'b1; oweReg = mHead.d1; oweData = res1;
            end else begin
               void'(mq.pop_front());
            end
         end
         if (mIss) begin
            mq.push_back(mNew);
            if (mNew.e0) cnt[mNew.d0]++;
            if (mNew.e1) cnt[mNew.d1]++;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Cycle-by-cycle comparison against the model, mid-cycle
   always @(negedge clk1) begin
      if (checkEn) begin
         checkOutput("dec_ready", dec_ready, mReady());
         checkOutput("issue_valid", issue_valid, dec_valid && mReady());
         checkOutput("stall", stall, rst_n && dec_valid && !mReady());
         checkOutput("wb_ready", wb_ready, rst_n && !owe2);
         checkOutput("busy_mask", busy_mask, mBusy());
         checkOutput("rf_we", rf_we, eWe);
         checkOutput("cpsr_we", cpsr_we, eCWe);
         if (eWe) begin
            checkOutput("rf_waddr", rf_waddr, eWaddr);
            checkOutput("rf_wdata", rf_wdata, eWdata);
         end
         if (eCWe) checkOutput("cpsr_wdata", cpsr_wdata, eCData);
      end
   end

   // One cycle of inputs, driven just after the rising edge
   task automatic applyStimulus(input logic v, input logic [NREGS-1:0] src,
                                input logic e0, input logic [3:0] d0,
                                input logic e1, input logic [3:0] d1,
                                input logic s, input logic ex,
                                input logic [31:0] r0, input logic [31:0] r1,
                                input logic [3:0] fl);
      @(posedge clk1);
      #1;
      dec_valid = v; dec_src_mask = src;
      dec_dst0_en = e0; dec_dst0 = d0;
      dec_dst1_en = e1; dec_dst1 = d1;
      dec_setflags = s; exec_done = ex;
      res0 = r0; res1 = r1; res_flags = fl;
   endtask

   task automatic idleCycle();
      applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic retire(input logic [31:0] r0, input logic [31:0] r1, input logic [3:0] fl);
      applyStimulus(0, '0, 0, 0, 0, 0, 0, 1, r0, r1, fl);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1 checkEn = 1'b1;
      @(negedge clk1);
      checkOutput("reset dec_ready", dec_ready, 0);
      checkOutput("reset wb_ready", wb_ready, 0);
      checkOutput("reset rf_waddr", rf_waddr, 0);
      checkOutput("reset rf_wdata", rf_wdata, 0);
      checkOutput("reset cpsr_wdata", cpsr_wdata, 0);
      checkOutput("reset busy_mask", busy_mask, 0);
      @(posedge clk1); #1 rst_n = 1'b1;

      $display("[TB] independent ops");
      applyStimulus(1, 16'h0006, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk1);
      checkOutput("indep issue1", issue_valid, 1);
      checkOutput("indep stall1", stall, 0);
      applyStimulus(1, 16'h0030, 1, 3, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk1);
      checkOutput("indep issue2", issue_valid, 1);
      checkOutput("indep busy", busy_mask, 16'h0001);
      retire(32'h8, 0, 0);
      retire(32'h9, 0, 0);
      @(negedge clk1);
      checkOutput("indep wr1 addr", rf_waddr, 0);
      checkOutput("indep wr1 data", rf_wdata, 32'h8);
      idleCycle();
      @(negedge clk1);
      checkOutput("indep wr2 we", rf_we, 1);
      checkOutput("indep wr2 addr", rf_waddr, 3);
      checkOutput("indep wr2 data", rf_wdata, 32'h9);
      idleCycle();

      $display("[TB] RAW hazard");
      applyStimulus(1, 16'h0006, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 16'h0003, 1, 5, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk1);
      checkOutput("raw stall", stall, 1);
      applyStimulus(1, 16'h0003, 1, 5, 0, 0, 0, 1, 32'h3, 0, 0);
      @(negedge clk1);
      checkOutput("raw no bypass", stall, 1);
      applyStimulus(1, 16'h0003, 1, 5, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk1);
      checkOutput("raw write r0", rf_we, 1);
      checkOutput("raw busy cleared", busy_mask, 0);
      checkOutput("raw issue", issue_valid, 1);
      retire(32'h11, 0, 0);
      @(negedge clk1);
      checkOutput("raw busy r5", busy_mask, 16'h0020);
      idleCycle();
      idleCycle();

      $display("[TB] long multiply");
      applyStimulus(1, 16'h0003, 1, 2, 1, 3, 1, 0, 0, 0, 0);
      retire(32'h0000002D, 32'h00000001, 4'b0110);
      idleCycle();
      @(negedge clk1);
      checkOutput("umull lo addr", rf_waddr, 2);
      checkOutput("umull lo data", rf_wdata, 32'h2D);
      checkOutput("umull cpsr_we", cpsr_we, 1);
      checkOutput("umull cpsr", cpsr_wdata, 4'b0110);
      checkOutput("umull wb_ready", wb_ready, 0);
      checkOutput("umull busy hi", busy_mask, 16'h0008);
      idleCycle();
      @(negedge clk1);
      checkOutput("umull hi we", rf_we, 1);
      checkOutput("umull hi addr", rf_waddr, 3);
      checkOutput("umull hi data", rf_wdata, 32'h1);
      checkOutput("umull hi cpsr_we", cpsr_we, 0);
      idleCycle();

      $display("[TB] queue full");
      for (int i = 0; i < DEPTH; i++) applyStimulus(1, '0, 1, 4'(i), 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, '0, 1, 4, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk1);
      checkOutput("full stall", stall, 1);
      checkOutput("full busy", busy_mask, 16'h000F);
      applyStimulus(1, '0, 1, 4, 0, 0, 0, 1, 32'h40, 0, 0);
      @(negedge clk1);
      checkOutput("full pop same cycle", dec_ready, 0);
      applyStimulus(1, '0, 1, 4, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk1);
      checkOutput("full issue after pop", issue_valid, 1);
      for (int i = 1; i <= 4; i++) retire(32'h40 + 32'(i), 0, 0);
      idleCycle();
      idleCycle();

      $display("[TB] compare class and empty retire");
      applyStimulus(1, 16'h0003, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      retire(32'hDEAD, 0, 4'b0100);
      idleCycle();
      @(negedge clk1);
      checkOutput("cmp rf_we", rf_we, 0);
      checkOutput("cmp cpsr_we", cpsr_we, 1);
      checkOutput("cmp cpsr", cpsr_wdata, 4'b0100);
      retire(32'hBEEF, 0, 4'b1111);
      idleCycle();
      @(negedge clk1);
      checkOutput("empty retire rf_we", rf_we, 0);
      checkOutput("empty retire cpsr_we", cpsr_we, 0);

      $display("[TB] reset mid-operation");
      applyStimulus(1, '0, 1, 6, 1, 7, 0, 0, 0, 0, 0);
      applyStimulus(1, '0, 1, 8, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, '0, 1, 9, 0, 0, 0, 0, 0, 0, 0);
      retire(32'h66, 32'h77, 0);
      idleCycle();
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst rf_we", rf_we, 0);
      checkOutput("rst busy", busy_mask, 0);
      checkOutput("rst wb_ready", wb_ready, 0);
      checkOutput("rst rf_wdata", rf_wdata, 0);
      @(posedge clk1); #1 rst_n = 1'b1;
      applyStimulus(1, 16'h0080, 1, 6, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk1);
      checkOutput("post-rst issue", issue_valid, 1);
      checkOutput("post-rst stall", stall, 0);
      retire(32'h5, 0, 0);
      idleCycle();
      idleCycle();

      @(negedge clk1);
      checkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Issue and write-back controller for the core pipeline, sitting between the decoder and the ALU/multiplier execute stage.
- Keeps a register scoreboard and stalls decode on RAW or WAW hazards against in-flight writes.
- Holds an in-order queue of issued destinations.
- Sequences the single register-bank write port and the CPSR write: one cycle for ALU/MUL/MLA, two consecutive cycles for UMULL/SMULL.

Parameters:
- DEPTH, 4, max in-flight issued-but-not-retired instructions (queue depth, power of two, >=2)
- NREGS, 16, architectural registers tracked by the scoreboard

Ports:
- clk1  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- dec_valid  in  1  decoder presents an instruction
- dec_ready  out  1  instruction accepted this cycle (issue)
- dec_src_mask  in  NREGS  one-hot-or bits of registers read (Rn/Rm/Rs/Ra)
- dec_dst0_en  in  1  first destination valid
- dec_dst0  in  4  first destination (Rd, or RdLo)
- dec_dst1_en  in  1  second destination valid (long multiply, RdHi)
- dec_dst1  in  4  second destination
- dec_setflags  in  1  S bit
- issue_valid  out  1  one-cycle pulse to execute, equal to dec_valid & dec_ready
- exec_done  in  1  execute result valid (in issue order)
- wb_ready  out  1  controller can accept exec_done this cycle
- res0  in  32  result for dst0
- res1  in  32  result for dst1
- res_flags  in  4  N,Z,C,V
- rf_we  out  1  register write strobe
- rf_waddr  out  4  register write address
- rf_wdata  out  32  register write data
- cpsr_we  out  1  flag write strobe
- cpsr_wdata  out  4  N,Z,C,V
- busy_mask  out  NREGS  registers with pending writes
- stall  out  1  dec_valid & ~dec_ready

Behaviour:
- Reset (async, immediate):
  - all outputs 0; rf_waddr/rf_wdata/cpsr_wdata are 0.
  - Scoreboard counters are 0, queue is empty, WB state is WB_IDLE.
  - Any in-flight work is discarded.
- Scoreboard:
  - Per-register pending counter, width clog2(DEPTH+1).
  - Issue increments dst0 (if en) and dst1 (if en). Retiring the write of register r decrements r.
  - Increment and decrement of the same register in the same cycle leaves it unchanged.
  - busy_mask[r] = (count[r] != 0), registered view.
- Issue condition: dec_ready = ~queue_full & ((dec_src_mask | dst masks) & busy_mask) == 0.
  - No same-cycle bypass: a source whose write retires this cycle still stalls for one cycle.
  - dst0 == dst1 with both enabled is illegal; the bench asserts against it.
- Queue: FIFO of {dst0_en, dst0, dst1_en, dst1, setflags}. Push on issue, pop on retire. Full at DEPTH entries.
- Execute is in-order. exec_done with an empty queue is a protocol error: ignored, no writes.
- WB state machine:
  - WB_IDLE, wb_ready = 1. On exec_done, registered outputs next cycle:
    - rf_we = dst0_en, rf_waddr = dst0, rf_wdata = res0.
    - cpsr_we = setflags, cpsr_wdata = res_flags.
    - If dst1_en: latch res1, go to WB_SECOND, do not pop. Otherwise pop the head and stay in WB_IDLE.
  - WB_SECOND, wb_ready = 0:
    - rf_we = 1, rf_waddr = dst1, rf_wdata = latched res1, cpsr_we = 0.
    - Pop the head, return to WB_IDLE.
  - Latency: exec_done to rf_we = 1 cycle; the second write of a long multiply follows at +2.
  - Scoreboard decrement takes effect on the same edge as the corresponding rf_we assertion.
- An entry with no destination and S=1 (compare class) produces cpsr_we only, in one cycle.
- Full queue with retire and issue in the same cycle: the pop frees the slot only on the next cycle, so dec_ready stays 0 this cycle.

Optional Feature:
- Macro: PIPE_HAZARD_STATS_EN.
- With it:
  - Extra output stall_count (32), incrementing on every stall cycle and saturating at 0xFFFFFFFF.
  - Extra output raw_count (32), incrementing on stalls caused by a source-register hazard rather than a full queue.
  - Both counters cleared by reset.
- Without it: neither port exists and there is no counter logic.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - NREGS default
  - WB state enum {WB_IDLE, WB_SECOND}
  - queue entry struct
  - flag bit index constants N=3, Z=2, C=1, V=0
- Sub-module: pipe_ctrl_queue, a parameterised synchronous FIFO with full/empty flags and async active-low reset.

Test Plan:
- Independent ops:
  - Stimulus: issue ADD r0 <- r1,r2, then ADD r3 <- r4,r5 back-to-back.
  - Response: no stall; both issue_valid pulses; exec_done with res0=0x8 then 0x9 gives writes r0=0x8, then r3=0x9 on consecutive cycles.
- RAW hazard:
  - Stimulus: issue r0 <- r1+r2, then r5 <- r0 AND r1.
  - Response: stall=1 until the cycle after rf_we to r0, then issue; busy_mask bit 0 clears on the write edge.
- Long multiply:
  - Stimulus: UMULL dst0=r2, dst1=r3, res0=0x0000002D, res1=0x00000001, S=1.
  - Response: cycle+1 writes r2=0x2D with cpsr_we; cycle+2 writes r3=0x1; wb_ready=0 during WB_SECOND.
- Queue full:
  - Stimulus: issue DEPTH=4 independent ops with no exec_done.
  - Response: 5th instruction stalls until one retire completes; the queue never overflows.
- Compare class:
  - Stimulus: no dst, S=1, res_flags=4'b0100.
  - Response: cpsr_we=1, cpsr_wdata=0100, rf_we=0, entry popped.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 while in WB_SECOND with 3 entries queued.
  - Response: outputs go to 0 immediately, busy_mask=0, next instruction issues without stall after release.
